// File: rtl/button_press_classifier.sv
// button_press_classifier
//   Turns the debounced button level into one-cycle user events: a short
//   press, a long press, and auto-repeat strobes while the button is held.
//   The timebase is an internal 1 ms tick derived from CLK_FREQUENCY.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   debounce      debounced button level (active-high, synchronous to clk)
//   enable        classifier enable; low forces the FSM back to idle
//   short_press   strobe: button released before LONG_MS
//   long_press    strobe: LONG_MS reached while held
//   repeat_press  strobe: every REPEAT_MS while in the long-press state
//   held          high while a press is being tracked
//   hold_ms       elapsed ms of the current/last press (saturating)
module button_press_classifier #(
   parameter int CLK_FREQUENCY = 10_000_000,
   parameter int LONG_MS       = 1000,
   parameter int REPEAT_MS     = 200,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 debounce,
   input  logic                 enable,
   output logic                 short_press,
   output logic                 long_press,
   output logic                 repeat_press,
   output logic                 held,
   output logic [CNT_WIDTH-1:0] hold_ms
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRESS = 2'd1;
   localparam logic [1:0] S_LONG  = 2'd2;

   // prescaler sizing: counts 0 .. CLK_FREQUENCY/1000-1
   localparam int PRE_TC = CLK_FREQUENCY / 1000 - 1;
   localparam int PW     = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
   localparam logic [PW-1:0] PRE_TC_V = PW'(PRE_TC);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH:0]   LONG_V   = (CNT_WIDTH+1)'(LONG_MS);
   localparam logic [CNT_WIDTH:0]   REPEAT_V = (CNT_WIDTH+1)'(REPEAT_MS);

   logic [1:0]           state;
   logic                 prev;
   logic [PW-1:0]        presc;
   logic [CNT_WIDTH-1:0] rep_cnt;
   logic                 tick;
   logic [CNT_WIDTH:0]   hold_nxt;
   logic [CNT_WIDTH:0]   rep_nxt;
   logic [CNT_WIDTH-1:0] hold_sat;

   assign tick     = (state != S_IDLE) && (presc == PRE_TC_V);
   // one bit wider so the "+1 == target" compares cannot wrap
   assign hold_nxt = {1'b0, hold_ms} + (CNT_WIDTH+1)'(1);
   assign rep_nxt  = {1'b0, rep_cnt} + (CNT_WIDTH+1)'(1);
   assign hold_sat = (hold_ms == CNT_MAX) ? hold_ms : hold_nxt[CNT_WIDTH-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         // starts high so a button already down at reset is not a press
         prev         <= 1'b1;
         presc        <= '0;
         rep_cnt      <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_press <= 1'b0;
         held         <= 1'b0;
         hold_ms      <= '0;
      end else begin
         prev         <= debounce;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_press <= 1'b0;
         if (state != S_IDLE)
            presc <= tick ? '0 : presc + PW'(1);
         case (state)
            S_IDLE: begin
               presc <= '0;
               if (enable && debounce && !prev) begin
                  state   <= S_PRESS;
                  hold_ms <= '0;
                  held    <= 1'b1;
               end
            end
            S_PRESS: begin
               if (!enable) begin
                  state <= S_IDLE;
                  held  <= 1'b0;
               end else if (!debounce) begin
                  // release beats a coincident LONG_MS tick
                  state       <= S_IDLE;
                  held        <= 1'b0;
                  short_press <= 1'b1;
               end else if (tick) begin
                  hold_ms <= hold_sat;
                  if (hold_nxt == LONG_V) begin
                     state      <= S_LONG;
                     long_press <= 1'b1;
                     rep_cnt    <= '0;
                  end
               end
            end
            S_LONG: begin
               if (!enable || !debounce) begin
                  // leaving LONG is silent, and swallows a coincident repeat
                  state <= S_IDLE;
                  held  <= 1'b0;
               end else if (tick) begin
                  hold_ms <= hold_sat;
                  if (REPEAT_MS != 0 && rep_nxt == REPEAT_V) begin
                     repeat_press <= 1'b1;
                     rep_cnt      <= '0;
                  end else begin
                     rep_cnt <= rep_nxt[CNT_WIDTH-1:0];
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier.
//   Two instances share the stimulus: "a" (1 ms = 10 clk, LONG_MS=5,
//   REPEAT_MS=2, 16-bit counters) and "b" (same tick, LONG_MS=2, 3-bit
//   counters) to exercise hold_ms saturation. A reference model expressed
//   as tick counts since the press edge predicts every output each cycle.
module tb_button_press_classifier;

   localparam int CF  = 10_000;
   localparam int P   = CF / 1000;
   localparam int RMS = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic debounce = 1'b0;
   logic enable = 1'b0;

   logic        a_short, a_long, a_rep, a_held;
   logic [15:0] a_hold;
   logic        b_short, b_long, b_rep, b_held;
   logic [2:0]  b_hold;

   always #5 clk = ~clk;

   button_press_classifier #(.CLK_FREQUENCY(CF), .LONG_MS(5), .REPEAT_MS(RMS), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .debounce(debounce), .enable(enable),
      .short_press(a_short), .long_press(a_long), .repeat_press(a_rep),
      .held(a_held), .hold_ms(a_hold));

   button_press_classifier #(.CLK_FREQUENCY(CF), .LONG_MS(2), .REPEAT_MS(RMS), .CNT_WIDTH(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .debounce(debounce), .enable(enable),
      .short_press(b_short), .long_press(b_long), .repeat_press(b_rep),
      .held(b_held), .hold_ms(b_hold));

   int checks = 0;
   int errors = 0;

   // model state per instance
   int lms[2]  = '{5, 2};
   int hmax[2] = '{65535, 7};
   bit m_act[2], m_lng[2], m_prev[2];
   int m_k[2], m_n[2];
   int e_short[2], e_long[2], e_rep[2], e_held[2], e_hold[2];

   int cs, cl, cr;   // strobe counts seen on instance a

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_lng[i] = 0; m_prev[i] = 1; m_k[i] = 0; m_n[i] = 0;
         e_short[i] = 0; e_long[i] = 0; e_rep[i] = 0; e_held[i] = 0; e_hold[i] = 0;
      end
   endtask

   // One clock edge: events follow from how many 1 ms ticks have elapsed
   // since the press was accepted (a tick ends every P-th cycle in a press).
   task automatic model_step(input bit d, input bit e);
      bit po, tk;
      for (int i = 0; i < 2; i++) begin
         po = m_prev[i];
         m_prev[i] = d;
         e_short[i] = 0; e_long[i] = 0; e_rep[i] = 0;
         if (!m_act[i]) begin
            if (e && d && !po) begin
               m_act[i] = 1; m_lng[i] = 0; m_k[i] = 0; m_n[i] = 0;
               e_hold[i] = 0; e_held[i] = 1;
            end
         end else begin
            tk = (m_k[i] % P) == P - 1;
            m_k[i]++;
            if (!e) begin
               m_act[i] = 0; e_held[i] = 0;
            end else if (!d) begin
               m_act[i] = 0; e_held[i] = 0;
               if (!m_lng[i]) e_short[i] = 1;
            end else if (tk) begin
               m_n[i]++;
               e_hold[i] = (m_n[i] > hmax[i]) ? hmax[i] : m_n[i];
               if (!m_lng[i]) begin
                  if (m_n[i] == lms[i]) begin
                     e_long[i] = 1; m_lng[i] = 1;
                  end
               end else if (RMS != 0 && (m_n[i] - lms[i]) % RMS == 0) begin
                  e_rep[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("a.short", a_short, e_short[0]);
      chk("a.long",  a_long,  e_long[0]);
      chk("a.rep",   a_rep,   e_rep[0]);
      chk("a.held",  a_held,  e_held[0]);
      chk("a.hold",  a_hold,  e_hold[0]);
      chk("a.onehot", 32'(a_short) + 32'(a_long) + 32'(a_rep) <= 1, 1);
      chk("b.short", b_short, e_short[1]);
      chk("b.long",  b_long,  e_long[1]);
      chk("b.rep",   b_rep,   e_rep[1]);
      chk("b.held",  b_held,  e_held[1]);
      chk("b.hold",  b_hold,  e_hold[1]);
      if (a_short === 1'b1) cs++;
      if (a_long  === 1'b1) cl++;
      if (a_rep   === 1'b1) cr++;
   endtask

   task automatic run(input bit d, input bit e, input int n);
      repeat (n) begin
         debounce = d;
         enable   = e;
         @(posedge clk);
         model_step(d, e);
         #1;
         check_all();
      end
   endtask

   // asynchronous assert: outputs must clear before any clock edge
   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic clr();
      cs = 0; cl = 0; cr = 0;
   endtask

   initial begin
      enable = 1'b1;
      debounce = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // short press: 35 cycles held gives three ticks
      clr(); run(0, 1, 5); run(1, 1, 35); run(0, 1, 3);
      chk("t1.short_cnt", cs, 1); chk("t1.long_cnt", cl, 0); chk("t1.rep_cnt", cr, 0);
      chk("t1.hold_ms", a_hold, 3); chk("t1.held", a_held, 0);

      // long press with two repeats, silent release
      clr(); run(1, 1, 100); run(0, 1, 3);
      chk("t2.long_cnt", cl, 1); chk("t2.rep_cnt", cr, 2); chk("t2.short_cnt", cs, 0);
      chk("t2.held", a_held, 0);

      // button down through reset is not a press until re-pressed
      clr(); debounce = 1'b1; do_reset(); run(1, 1, 20);
      chk("t3.held", a_held, 0); chk("t3.short_cnt", cs, 0);
      run(0, 1, 2); run(1, 1, 15); run(0, 1, 3);
      chk("t3.short_after", cs, 1);

      // enable low at the press edge, then enable dropped mid-press
      clr(); run(0, 0, 3); run(1, 0, 3); run(1, 1, 10);
      chk("t4.ignored", a_held, 0);
      run(0, 1, 3); run(1, 1, 20);
      chk("t4.held", a_held, 1);
      run(1, 0, 1);
      chk("t4.drop", a_held, 0); chk("t4.hold_keep", a_hold, 1);
      run(1, 0, 3); run(0, 1, 3);
      chk("t4.no_strobe", cs + cl + cr, 0);

      // release coincident with the LONG_MS tick
      clr(); run(0, 1, 3); run(1, 1, 50); run(0, 1, 3);
      chk("t5.short_cnt", cs, 1); chk("t5.long_cnt", cl, 0); chk("t5.hold_ms", a_hold, 4);

      // reset while in LONG, then saturation on the 3-bit instance
      clr(); run(1, 1, 70);
      chk("t6.in_long", cl, 1);
      reset_n = 1'b0; model_reset(); #1;
      chk("t6.rst_held", a_held, 0); chk("t6.rst_hold", a_hold, 0);
      check_all();
      @(posedge clk); #1; reset_n = 1'b1;
      run(1, 1, 30);
      chk("t6.need_release", a_held, 0);
      run(0, 1, 2); run(1, 1, 150);
      chk("t6.b_sat", b_hold, 7); chk("t6.a_hold", a_hold, 14);
      run(0, 1, 3);

      // randomized segments
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 24) == 0) do_reset();
         run(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, $urandom_range(1, 120));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
